// File: rtl/ethermac_B_pkg.sv
// rtl/ethermac_B_pkg.sv - shared states, constants and CRC step for the B-side MII receiver
package ethermac_B_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_DATA     = 3'd2,
        ST_CHECK    = 3'd3,
        ST_DROP     = 3'd4
    } rx_state_e;

    localparam logic [3:0]  PREAMBLE_NIB  = 4'b0101;
    localparam logic [3:0]  SFD_NIB       = 4'b1101;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;
    localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
    localparam logic [9:0]  PORT_WORD_IDX = 10'd8;
    localparam logic [3:0]  MIN_PREAMBLE  = 4'd7;

    // One nibble of CRC-32; wire bit 0 goes in first, register kept in
    // MSB-first form so a good frame lands on the familiar C704DD7B residue.
    function automatic logic [31:0] crc32_nibble(input logic [31:0] crc, input logic [3:0] nib);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 4; i++) begin
            if (c[31] ^ nib[i]) begin
                c = {c[30:0], 1'b0} ^ CRC_POLY;
            end else begin
                c = {c[30:0], 1'b0};
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/ethmac_check_crc_B.sv
// rtl/ethmac_check_crc_B.sv - nibble-serial CRC-32 accumulator for received frames
module ethmac_check_crc_B
    import ethermac_B_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_crc_reset,
    input  logic        i_crc_enable,
    input  logic [3:0]  i_data,
    output logic [31:0] o_crc
);

    logic [31:0] crc_q;
    logic [31:0] crc_d;

    // Restart on frame start, otherwise fold in each enabled nibble.
    always_comb begin
        crc_d = crc_q;
        if (i_crc_reset) begin
            crc_d = CRC_INIT;
        end else if (i_crc_enable) begin
            crc_d = crc32_nibble(crc_q, i_data);
        end
    end

    // CRC register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            crc_q <= CRC_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign o_crc = crc_q;

endmodule

// File: rtl/ethermac_recv_b.sv
// rtl/ethermac_recv_b.sv - MII receive MAC: preamble/SFD lock, word assembly, RAM writes, frame status
module ethermac_recv_b
    import ethermac_B_pkg::*;
#(
    parameter logic [15:0] PKG_MAX_LENGTH = 16'd757
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ErxDv,
    input  logic        i_ErxEr,
    input  logic [3:0]  i_data,
    output logic        o_ram_wren,
    output logic [9:0]  o_ram_addr,
    output logic [15:0] o_ram_data,
    output logic [9:0]  o_length,
    output logic        o_recvDn,
    output logic        o_crc_err,
    output logic        o_len_err,
    output logic [1:0]  o_port_id,
    output logic        o_recvIdl
);

    // Payload plus the two FCS words; the write index saturates here.
    localparam logic [9:0] WORD_LIMIT = 10'(PKG_MAX_LENGTH + 16'd2);

    rx_state_e   state_q,   state_d;
    logic        dv_dly_q;
    logic [3:0]  pre_cnt_q, pre_cnt_d;
    logic [1:0]  phase_q,   phase_d;
    logic [9:0]  idx_q,     idx_d;
    // Pending word bits: [11:4] hold word[15:8], [3:0] hold word[3:0].
    logic [11:0] part_q,    part_d;
    logic        sticky_q,  sticky_d;
    logic        overrun_q, overrun_d;
    logic [1:0]  port_q,    port_d;
    logic        wren_q,    wren_d;
    logic [9:0]  addr_q,    addr_d;
    logic [15:0] data_q,    data_d;
    logic [9:0]  length_q,  length_d;
    logic        crc_err_q, crc_err_d;
    logic        len_err_q, len_err_d;
    logic [1:0]  port_id_q, port_id_d;
    logic        dn_q,      dn_d;
    logic        idl_q,     idl_d;

    logic        crc_reset;
    logic        crc_enable;
    logic [31:0] crc_val;

    ethmac_check_crc_B u_crc (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_crc_reset  (crc_reset),
        .i_crc_enable (crc_enable),
        .i_data       (i_data),
        .o_crc        (crc_val)
    );

    // Next-state logic: framing, nibble packing, write issue and end-of-frame report.
    always_comb begin
        state_d    = state_q;
        pre_cnt_d  = pre_cnt_q;
        phase_d    = phase_q;
        idx_d      = idx_q;
        part_d     = part_q;
        sticky_d   = sticky_q;
        overrun_d  = overrun_q;
        port_d     = port_q;
        wren_d     = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        length_d   = length_q;
        crc_err_d  = crc_err_q;
        len_err_d  = len_err_q;
        port_id_d  = port_id_q;
        dn_d       = 1'b0;
        crc_reset  = 1'b0;
        crc_enable = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_ErxDv) begin
                    if (!dv_dly_q && i_data == PREAMBLE_NIB) begin
                        state_d   = ST_PREAMBLE;
                        pre_cnt_d = 4'd1;
                    end else begin
                        state_d = ST_DROP;
                    end
                end
            end
            ST_PREAMBLE: begin
                if (!i_ErxDv) begin
                    state_d = ST_IDLE;
                end else if (i_data == PREAMBLE_NIB) begin
                    if (pre_cnt_q != 4'd15) begin
                        pre_cnt_d = pre_cnt_q + 4'd1;
                    end
                end else if (i_data == SFD_NIB && pre_cnt_q >= MIN_PREAMBLE) begin
                    state_d   = ST_DATA;
                    crc_reset = 1'b1;
                    idx_d     = 10'd0;
                    phase_d   = 2'd0;
                    sticky_d  = 1'b0;
                    overrun_d = 1'b0;
                    port_d    = 2'd0;
                end else begin
                    state_d = ST_DROP;
                end
            end
            ST_DATA: begin
                if (i_ErxEr) begin
                    sticky_d = 1'b1;
                end
                if (!i_ErxDv) begin
                    state_d = ST_CHECK;
                end else begin
                    crc_enable = 1'b1;
                    phase_d    = phase_q + 2'd1;
                    case (phase_q)
                        2'd0: part_d[7:4]  = i_data;
                        2'd1: part_d[11:8] = i_data;
                        2'd2: part_d[3:0]  = i_data;
                        default: begin
                            if (idx_q == WORD_LIMIT) begin
                                overrun_d = 1'b1;
                            end else begin
                                wren_d = 1'b1;
                                addr_d = idx_q;
                                data_d = {part_q[11:4], i_data, part_q[3:0]};
                                idx_d  = idx_q + 10'd1;
                                if (idx_q == PORT_WORD_IDX) begin
                                    port_d = i_data[1:0];
                                end
                            end
                        end
                    endcase
                end
            end
            ST_CHECK: begin
                state_d   = ST_IDLE;
                dn_d      = 1'b1;
                crc_err_d = (crc_val != CRC_RESIDUE) | sticky_q;
                len_err_d = (phase_q != 2'd0) | (idx_q < 10'd3) | overrun_q;
                length_d  = (idx_q >= 10'd2) ? (idx_q - 10'd2) : 10'd0;
                port_id_d = (idx_q > PORT_WORD_IDX) ? port_q : 2'd0;
            end
            ST_DROP: begin
                if (!i_ErxDv) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        idl_d = (state_d == ST_IDLE);
    end

    // FSM and registered outputs; dv_dly resets high so an in-flight frame is dropped.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            dv_dly_q  <= 1'b1;
            pre_cnt_q <= 4'd0;
            phase_q   <= 2'd0;
            idx_q     <= 10'd0;
            part_q    <= 12'd0;
            sticky_q  <= 1'b0;
            overrun_q <= 1'b0;
            port_q    <= 2'd0;
            wren_q    <= 1'b0;
            addr_q    <= 10'd0;
            data_q    <= 16'd0;
            length_q  <= 10'd0;
            crc_err_q <= 1'b0;
            len_err_q <= 1'b0;
            port_id_q <= 2'd0;
            dn_q      <= 1'b0;
            idl_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            dv_dly_q  <= i_ErxDv;
            pre_cnt_q <= pre_cnt_d;
            phase_q   <= phase_d;
            idx_q     <= idx_d;
            part_q    <= part_d;
            sticky_q  <= sticky_d;
            overrun_q <= overrun_d;
            port_q    <= port_d;
            wren_q    <= wren_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            length_q  <= length_d;
            crc_err_q <= crc_err_d;
            len_err_q <= len_err_d;
            port_id_q <= port_id_d;
            dn_q      <= dn_d;
            idl_q     <= idl_d;
        end
    end

    assign o_ram_wren = wren_q;
    assign o_ram_addr = addr_q;
    assign o_ram_data = data_q;
    assign o_length   = length_q;
    assign o_recvDn   = dn_q;
    assign o_crc_err  = crc_err_q;
    assign o_len_err  = len_err_q;
    assign o_port_id  = port_id_q;
    assign o_recvIdl  = idl_q;

endmodule

// File: tb/tb_ethermac_recv_b.sv
// tb/tb_ethermac_recv_b.sv - directed self-checking bench for ethermac_recv_b
module tb_ethermac_recv_b;

    logic        clk;
    logic        rst;
    logic        erx_dv;
    logic        erx_er;
    logic [3:0]  rx_data;
    logic        ram_wren;
    logic [9:0]  ram_addr;
    logic [15:0] ram_data;
    logic [9:0]  length;
    logic        recv_dn;
    logic        crc_err;
    logic        len_err;
    logic [1:0]  port_id;
    logic        recv_idl;

    int total = 0;
    int bad   = 0;

    logic [3:0]  dq[$];
    logic [9:0]  wa[$];
    logic [15:0] wd[$];
    int          dn_cnt;
    logic [9:0]  dn_len;
    logic        dn_crc;
    logic        dn_lenerr;
    logic [1:0]  dn_port;
    int          er_at;
    int          rst_at;
    int          wr_at_rst;

    ethermac_recv_b #(.PKG_MAX_LENGTH(16'd16)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_ErxDv    (erx_dv),
        .i_ErxEr    (erx_er),
        .i_data     (rx_data),
        .o_ram_wren (ram_wren),
        .o_ram_addr (ram_addr),
        .o_ram_data (ram_data),
        .o_length   (length),
        .o_recvDn   (recv_dn),
        .o_crc_err  (crc_err),
        .o_len_err  (len_err),
        .o_port_id  (port_id),
        .o_recvIdl  (recv_idl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Capture writes and end-of-frame reports away from the active edge.
    always @(negedge clk) begin
        if (ram_wren) begin
            wa.push_back(ram_addr);
            wd.push_back(ram_data);
        end
        if (recv_dn) begin
            dn_cnt    = dn_cnt + 1;
            dn_len    = length;
            dn_crc    = crc_err;
            dn_lenerr = len_err;
            dn_port   = port_id;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference CRC in reflected (shift-right) form.
    function automatic logic [31:0] crc_ref(input logic [31:0] c_in, input logic [3:0] n);
        logic [31:0] c;
        c = c_in;
        for (int i = 0; i < 4; i++) begin
            if (c[0] ^ n[i]) c = (c >> 1) ^ 32'hEDB88320;
            else             c = c >> 1;
        end
        return c;
    endfunction

    task automatic add_word(input logic [15:0] w);
        dq.push_back(w[11:8]);
        dq.push_back(w[15:12]);
        dq.push_back(w[3:0]);
        dq.push_back(w[7:4]);
    endtask

    task automatic build_payload(input int n, input logic [3:0] p8);
        dq.delete();
        for (int i = 0; i < n; i++) begin
            add_word({4'(i), 4'h3, (i == 8) ? p8 : 4'h5, 4'(15 - i)});
        end
    endtask

    task automatic add_fcs();
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (dq[i]) c = crc_ref(c, dq[i]);
        c = ~c;
        for (int k = 0; k < 8; k++) dq.push_back(c[4*k +: 4]);
    endtask

    function automatic logic [15:0] exp_word(input int g);
        return {dq[4*g+1], dq[4*g], dq[4*g+3], dq[4*g+2]};
    endfunction

    task automatic drive(input logic dv, input logic [3:0] nib, input logic er);
        @(negedge clk);
        erx_dv  = dv;
        rx_data = nib;
        erx_er  = er;
    endtask

    task automatic clear_mon();
        wa.delete();
        wd.delete();
        dn_cnt = 0;
    endtask

    // Send first nibble, npre more preamble nibbles, the SFD, then dq; then idle.
    task automatic send(input logic [3:0] first, input int npre);
        clear_mon();
        drive(1'b1, first, 1'b0);
        for (int i = 0; i < npre; i++) drive(1'b1, 4'b0101, 1'b0);
        drive(1'b1, 4'b1101, 1'b0);
        for (int i = 0; i < dq.size(); i++) begin
            drive(1'b1, dq[i], (i == er_at));
            if (i == rst_at) begin
                wr_at_rst = wa.size();
                #1 rst = 1'b1;
                #2 rst = 1'b0;
            end
        end
        drive(1'b0, 4'h0, 1'b0);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 30 && !recv_idl; i++) @(negedge clk);
        chk("idle_after_frame", 32'(recv_idl), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_writes(input int n);
        chk("write_count", 32'(wa.size()), 32'(n));
        for (int i = 0; i < n && i < wa.size(); i++) begin
            chk("wr_addr", 32'(wa[i]), 32'(i));
            chk("wr_data", 32'(wd[i]), 32'(exp_word(i)));
        end
    endtask

    initial begin
        rst = 1'b1;
        erx_dv = 1'b0;
        erx_er = 1'b0;
        rx_data = 4'h0;
        er_at = -1;
        rst_at = -1;
        wr_at_rst = 0;
        dn_cnt = 0;
        dn_len = '0;
        dn_crc = 1'b0;
        dn_lenerr = 1'b0;
        dn_port = '0;
        repeat (2) @(negedge clk);
        chk("rst_idl",    32'(recv_idl), 32'd1);
        chk("rst_wren",   32'(ram_wren), 32'd0);
        chk("rst_dn",     32'(recv_dn),  32'd0);
        chk("rst_length", 32'(length),   32'd0);
        chk("rst_crcerr", 32'(crc_err),  32'd0);
        chk("rst_lenerr", 32'(len_err),  32'd0);
        chk("rst_port",   32'(port_id),  32'd0);
        chk("rst_addr",   32'(ram_addr), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Good frame: 12 words + FCS.
        build_payload(12, 4'h5);
        add_fcs();
        send(4'b0101, 14);
        check_writes(14);
        chk("good_dn",     32'(dn_cnt),    32'd1);
        chk("good_len",    32'(dn_len),    32'd12);
        chk("good_crcerr", 32'(dn_crc),    32'd0);
        chk("good_lenerr", 32'(dn_lenerr), 32'd0);
        chk("good_port",   32'(dn_port),   32'd1);

        // Flipped payload nibble after FCS computed.
        build_payload(12, 4'h5);
        add_fcs();
        dq[5] = dq[5] ^ 4'h1;
        send(4'b0101, 14);
        check_writes(14);
        chk("badcrc_dn",     32'(dn_cnt),    32'd1);
        chk("badcrc_crcerr", 32'(dn_crc),    32'd1);
        chk("badcrc_lenerr", 32'(dn_lenerr), 32'd0);

        // Receive error pulse on one data nibble.
        build_payload(12, 4'h5);
        add_fcs();
        er_at = 9;
        send(4'b0101, 14);
        er_at = -1;
        chk("erxer_dn",     32'(dn_cnt), 32'd1);
        chk("erxer_crcerr", 32'(dn_crc), 32'd1);

        // Port id from word 8 bits [5:4].
        build_payload(12, 4'b1110);
        add_fcs();
        send(4'b0101, 14);
        chk("port_dn",     32'(dn_cnt),  32'd1);
        chk("port_id",     32'(dn_port), 32'd2);
        chk("port_crcerr", 32'(dn_crc),  32'd0);

        // Short preamble (5 nibbles).
        build_payload(12, 4'h5);
        add_fcs();
        send(4'b0101, 4);
        chk("shortpre_writes", 32'(wa.size()), 32'd0);
        chk("shortpre_dn",     32'(dn_cnt),    32'd0);

        // Bad first nibble.
        send(4'b0011, 15);
        chk("badpre_writes", 32'(wa.size()), 32'd0);
        chk("badpre_dn",     32'(dn_cnt),    32'd0);

        // Odd alignment: 10 words plus 2 nibbles.
        build_payload(10, 4'h5);
        dq.push_back(4'h7);
        dq.push_back(4'h8);
        send(4'b0101, 14);
        check_writes(10);
        chk("odd_dn",     32'(dn_cnt),    32'd1);
        chk("odd_lenerr", 32'(dn_lenerr), 32'd1);
        chk("odd_len",    32'(dn_len),    32'd8);

        // Overrun: max 16 payload words, 20 sent.
        build_payload(20, 4'h5);
        add_fcs();
        send(4'b0101, 14);
        check_writes(18);
        chk("ovr_last_addr", (wa.size() > 0) ? 32'(wa[wa.size()-1]) : 32'hFFFF, 32'd17);
        chk("ovr_dn",     32'(dn_cnt),    32'd1);
        chk("ovr_lenerr", 32'(dn_lenerr), 32'd1);
        chk("ovr_len",    32'(dn_len),    32'd16);
        chk("ovr_crcerr", 32'(dn_crc),    32'd0);

        // Reset during DATA with DV held high.
        build_payload(12, 4'h5);
        add_fcs();
        rst_at = 22;
        send(4'b0101, 14);
        rst_at = -1;
        chk("midrst_writes_before", 32'(wr_at_rst), 32'd5);
        chk("midrst_writes_total",  32'(wa.size()), 32'd5);
        chk("midrst_dn",            32'(dn_cnt),    32'd0);

        // Next frame received normally.
        send(4'b0101, 14);
        check_writes(14);
        chk("after_rst_dn",     32'(dn_cnt),    32'd1);
        chk("after_rst_len",    32'(dn_len),    32'd12);
        chk("after_rst_crcerr", 32'(dn_crc),    32'd0);
        chk("after_rst_lenerr", 32'(dn_lenerr), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
